sht40_meas_ctrl: RTL and testbench
==================================

// Module: sht40_meas_ctrl
// PURPOSE
//  Upstream sequencer for i2c_master + i2c_sht40; replaces the static processor stimulus.
//  Per measurement:
//   - issues the write transaction (address + command frame)
//   - waits the sensor conversion time, then issues the read transaction
//   - collects Temperature_Output/Humidity_Output; retries on CRC error or timeout
//  Single-shot on Start, or periodic when Auto_Mode=1.
// PARAMETERS
//  SENSOR_ADDR     7'h44    peripheral address driven on Peripheral_Address
//  MEAS_CMD        8'hFD    command frame (high-precision T+RH)
//  CONV_CYCLES     24'd850000  clk cycles between write done and read request
//  PERIOD_CYCLES   24'd1000000 Auto_Mode gap, DONE/ERROR -> next CMD_REQ
//  TIMEOUT_CYCLES  24'd200000  max cycles in any *_WAIT master state before retry
//  MAX_RETRIES     2'd3     retries after first attempt before ERROR
//  MASTER_IDLE     3'b000   Master_State_Out encoding for idle
// PORTS
//  clk                  in   1   system clock, all logic on posedge
//  Reset_N              in   1   asynchronous, active-low reset
//  Start                in   1   1-cycle pulse: begin measurement (ignored unless IDLE)
//  Auto_Mode            in   1   1 = repeat measurements every PERIOD_CYCLES
//  Master_State_Out     in   3   i2c_master state
//  Temp_Ready_Out       in   1   i2c_sht40: temperature word valid
//  RH_Ready_Out         in   1   i2c_sht40: humidity word valid
//  CRC_Error_Out        in   1   i2c_sht40: CRC mismatch on current read
//  Temperature_Output   in   16  raw temperature ticks
//  Humidity_Output      in   16  raw humidity ticks
//  Processor_Ready      out  1   transaction request to i2c_master
//  i2c_writes           out  1   1 = write (command), 0 = read
//  Peripheral_Address   out  7   constant SENSOR_ADDR
//  Command_Data_Frames  out  8   constant MEAS_CMD
//  Temp_Raw             out  16  last good temperature sample
//  RH_Raw               out  16  last good humidity sample
//  Sample_Valid         out  1   1-cycle pulse: Temp_Raw/RH_Raw updated
//  Sample_Error         out  1   1-cycle pulse: retries exhausted
//  Retry_Count          out  2   retries used in current measurement
//  Busy                 out  1   state != IDLE
// BEHAVIOUR
//  Reset values (async, immediate):
//   - state IDLE; Processor_Ready=0, i2c_writes=1
//   - Temp_Raw=RH_Raw=0; Sample_Valid=Sample_Error=0; Retry_Count=0, Busy=0
//  Address/command outputs are constant, unaffected by reset.
//  Single 24-bit down-counter shared by CONV, TIMEOUT and PERIOD waits; loaded on state entry.
//  FSM:
//   IDLE -> CMD_REQ: on Start, or Auto_Mode rising.
//   CMD_REQ: Processor_Ready=1, i2c_writes=1; master leaves MASTER_IDLE -> CMD_WAIT, Processor_Ready=0 next cycle.
//   CMD_WAIT: master back at MASTER_IDLE -> CONV_WAIT.
//   CONV_WAIT: counter hits 0 -> RD_REQ. Latency CONV_CYCLES+1 from entry.
//   RD_REQ: as CMD_REQ with i2c_writes=0 -> RD_WAIT; clear sticky T/RH flags on entry.
//   RD_WAIT: set sticky flags on Temp_Ready_Out/RH_Ready_Out.
//    - both set and master idle -> DONE
//    - CRC_Error_Out -> RETRY
//   RETRY: Retry_Count==MAX_RETRIES -> ERROR, else Retry_Count+1 -> CMD_REQ.
//   DONE: latch Temp_Raw/RH_Raw, pulse Sample_Valid, Retry_Count=0.
//    - Auto_Mode -> PERIOD_WAIT, else IDLE
//   ERROR: pulse Sample_Error; Temp_Raw/RH_Raw hold; Retry_Count=0.
//    - Auto_Mode -> PERIOD_WAIT, else IDLE
//   PERIOD_WAIT: counter 0 -> CMD_REQ; Auto_Mode=0 -> IDLE immediately.
//  Timeout: counter reaching 0 in CMD_REQ/CMD_WAIT/RD_REQ/RD_WAIT -> RETRY, Processor_Ready=0.
//  Simultaneous events:
//   - CRC_Error_Out with both ready flags -> CRC wins (RETRY)
//   - timeout with completion in same cycle -> completion wins
//   - Start outside IDLE ignored; Auto_Mode drop mid-measurement completes it, then IDLE
//  Sample_Valid and Sample_Error are never high together.
// STRUCTURE
//  Package sht40_pkg: FSM state localparams, 4-bit encoding, IDLE=0:
//   IDLE, CMD_REQ, CMD_WAIT, CONV_WAIT, RD_REQ, RD_WAIT, RETRY, DONE, ERROR, PERIOD_WAIT
//  Also in sht40_pkg: MASTER_IDLE default, SHT40 address/command constants.
//  Sub-module sht40_wait_timer: loadable 24-bit down-counter with zero flag.
// TESTING (bench: CONV_CYCLES=20, PERIOD_CYCLES=50, TIMEOUT_CYCLES=100)
//  1 Reset: Reset_N=0 mid-CONV_WAIT -> all outputs at reset values same cycle; Busy=0.
//  2 Nominal: Start; model returns 16'hBEEF / 16'h92AB, no CRC error
//     -> write then read issued, read REQ >=20 cycles after write done
//     -> Sample_Valid 1 cycle, Temp_Raw=16'hBEEF, RH_Raw=16'h92AB.
//  3 CRC retry: CRC_Error_Out on first read only -> Retry_Count=1, second write+read -> Sample_Valid.
//  4 Exhaust: CRC error on every read -> 4 attempts, Sample_Error pulse, Temp_Raw unchanged, IDLE.
//  5 Timeout: master stuck non-idle -> RETRY after 100 cycles, Processor_Ready=0.
//  6 Auto: Auto_Mode=1 -> samples spaced by 50-cycle gap; Auto_Mode=0 in PERIOD_WAIT -> IDLE next cycle.

Source files
------------

// File: rtl/sht40_pkg.sv
// Shared constants and FSM state encoding for the SHT40 measurement sequencer.
package sht40_pkg;

    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_CMD_REQ     = 4'd1,
        ST_CMD_WAIT    = 4'd2,
        ST_CONV_WAIT   = 4'd3,
        ST_RD_REQ      = 4'd4,
        ST_RD_WAIT     = 4'd5,
        ST_RETRY       = 4'd6,
        ST_DONE        = 4'd7,
        ST_ERROR       = 4'd8,
        ST_PERIOD_WAIT = 4'd9
    } state_e;

    localparam logic [2:0]  MASTER_IDLE_DEF    = 3'b000;
    localparam logic [6:0]  SENSOR_ADDR_DEF    = 7'h44;
    localparam logic [7:0]  MEAS_CMD_DEF       = 8'hFD;
    localparam logic [23:0] CONV_CYCLES_DEF    = 24'd850000;
    localparam logic [23:0] PERIOD_CYCLES_DEF  = 24'd1000000;
    localparam logic [23:0] TIMEOUT_CYCLES_DEF = 24'd200000;
    localparam logic [1:0]  MAX_RETRIES_DEF    = 2'd3;

endpackage

// File: rtl/sht40_wait_timer.sv
// Loadable 24-bit down-counter; saturates at zero and flags it.
module sht40_wait_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        srst,
    input  logic        load,
    input  logic [23:0] load_value,
    output logic        zero
);

    logic [23:0] count_r;

    // Count register: a load always wins, otherwise step toward zero and stop there
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= 24'd0;
        end else if (srst) begin
            count_r <= 24'd0;
        end else if (load) begin
            count_r <= load_value;
        end else if (count_r != 24'd0) begin
            count_r <= count_r - 24'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == 24'd0);

endmodule

// File: rtl/sht40_meas_ctrl.sv
// Sequences write/convert/read transactions through i2c_master + i2c_sht40,
// retrying on CRC error or bus timeout, single-shot or periodic.
module sht40_meas_ctrl
    import sht40_pkg::*;
#(
    parameter logic [6:0]  SENSOR_ADDR    = SENSOR_ADDR_DEF,
    parameter logic [7:0]  MEAS_CMD       = MEAS_CMD_DEF,
    parameter logic [23:0] CONV_CYCLES    = CONV_CYCLES_DEF,
    parameter logic [23:0] PERIOD_CYCLES  = PERIOD_CYCLES_DEF,
    parameter logic [23:0] TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter logic [1:0]  MAX_RETRIES    = MAX_RETRIES_DEF,
    parameter logic [2:0]  MASTER_IDLE    = MASTER_IDLE_DEF
) (
    input  logic        clk,
    input  logic        Reset_N,
    input  logic        srst,
    input  logic        Start,
    input  logic        Auto_Mode,
    input  logic [2:0]  Master_State_Out,
    input  logic        Temp_Ready_Out,
    input  logic        RH_Ready_Out,
    input  logic        CRC_Error_Out,
    input  logic [15:0] Temperature_Output,
    input  logic [15:0] Humidity_Output,
    output logic        Processor_Ready,
    output logic        i2c_writes,
    output logic [6:0]  Peripheral_Address,
    output logic [7:0]  Command_Data_Frames,
    output logic [15:0] Temp_Raw,
    output logic [15:0] RH_Raw,
    output logic        Sample_Valid,
    output logic        Sample_Error,
    output logic [1:0]  Retry_Count,
    output logic        Busy
);

    state_e      state_r, state_s;
    logic        auto_d_r, t_seen_r, rh_seen_r;
    logic [15:0] temp_cap_r, rh_cap_r, temp_sel_s, rh_sel_s;
    logic        t_seen_s, rh_seen_s, master_idle_s, zero_s, load_s;
    logic [23:0] load_value_s;

    assign Peripheral_Address  = SENSOR_ADDR;
    assign Command_Data_Frames = MEAS_CMD;
    assign master_idle_s       = (Master_State_Out == MASTER_IDLE);
    assign t_seen_s            = t_seen_r | Temp_Ready_Out;
    assign rh_seen_s           = rh_seen_r | RH_Ready_Out;

    sht40_wait_timer u_timer (
        .clk        (clk),
        .rst_n      (Reset_N),
        .srst       (srst),
        .load       (load_s),
        .load_value (load_value_s),
        .zero       (zero_s)
    );

    // Next-state logic; handshake completion is tested ahead of the timeout
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (Start || (Auto_Mode && !auto_d_r)) state_s = ST_CMD_REQ;
                else                                   state_s = ST_IDLE;
            end
            ST_CMD_REQ: begin
                if (!master_idle_s) state_s = ST_CMD_WAIT;
                else if (zero_s)    state_s = ST_RETRY;
                else                state_s = ST_CMD_REQ;
            end
            ST_CMD_WAIT: begin
                if (master_idle_s) state_s = ST_CONV_WAIT;
                else if (zero_s)   state_s = ST_RETRY;
                else               state_s = ST_CMD_WAIT;
            end
            ST_CONV_WAIT: begin
                if (zero_s) state_s = ST_RD_REQ;
                else        state_s = ST_CONV_WAIT;
            end
            ST_RD_REQ: begin
                if (!master_idle_s) state_s = ST_RD_WAIT;
                else if (zero_s)    state_s = ST_RETRY;
                else                state_s = ST_RD_REQ;
            end
            ST_RD_WAIT: begin
                if (CRC_Error_Out)                               state_s = ST_RETRY;
                else if (t_seen_s && rh_seen_s && master_idle_s) state_s = ST_DONE;
                else if (zero_s)                                 state_s = ST_RETRY;
                else                                             state_s = ST_RD_WAIT;
            end
            ST_RETRY: begin
                if (Retry_Count == MAX_RETRIES) state_s = ST_ERROR;
                else                            state_s = ST_CMD_REQ;
            end
            ST_DONE, ST_ERROR: begin
                if (Auto_Mode) state_s = ST_PERIOD_WAIT;
                else           state_s = ST_IDLE;
            end
            ST_PERIOD_WAIT: begin
                if (!Auto_Mode)  state_s = ST_IDLE;
                else if (zero_s) state_s = ST_CMD_REQ;
                else             state_s = ST_PERIOD_WAIT;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Shared timer is reloaded only on entry to a state that waits on it
    always_comb begin
        load_s       = 1'b0;
        load_value_s = 24'd0;
        if (state_s != state_r) begin
            case (state_s)
                ST_CMD_REQ, ST_CMD_WAIT, ST_RD_REQ, ST_RD_WAIT: begin
                    load_s       = 1'b1;
                    load_value_s = TIMEOUT_CYCLES;
                end
                ST_CONV_WAIT: begin
                    load_s       = 1'b1;
                    load_value_s = CONV_CYCLES;
                end
                ST_PERIOD_WAIT: begin
                    load_s       = 1'b1;
                    load_value_s = PERIOD_CYCLES;
                end
                default: begin
                    load_s       = 1'b0;
                    load_value_s = 24'd0;
                end
            endcase
        end else begin
            load_s       = 1'b0;
            load_value_s = 24'd0;
        end
    end

    // A word arriving in the completing cycle bypasses the capture register
    always_comb begin
        temp_sel_s = temp_cap_r;
        rh_sel_s   = rh_cap_r;
        if (Temp_Ready_Out) temp_sel_s = Temperature_Output;
        else                temp_sel_s = temp_cap_r;
        if (RH_Ready_Out) rh_sel_s = Humidity_Output;
        else              rh_sel_s = rh_cap_r;
    end

    // State register and outputs, all decoded from the upcoming state
    always_ff @(posedge clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state_r         <= ST_IDLE;
            auto_d_r        <= 1'b0;
            Processor_Ready <= 1'b0;
            i2c_writes      <= 1'b1;
            Busy            <= 1'b0;
            Sample_Valid    <= 1'b0;
            Sample_Error    <= 1'b0;
            Retry_Count     <= 2'd0;
            Temp_Raw        <= 16'd0;
            RH_Raw          <= 16'd0;
        end else if (srst) begin
            state_r         <= ST_IDLE;
            auto_d_r        <= 1'b0;
            Processor_Ready <= 1'b0;
            i2c_writes      <= 1'b1;
            Busy            <= 1'b0;
            Sample_Valid    <= 1'b0;
            Sample_Error    <= 1'b0;
            Retry_Count     <= 2'd0;
            Temp_Raw        <= 16'd0;
            RH_Raw          <= 16'd0;
        end else begin
            state_r         <= state_s;
            auto_d_r        <= Auto_Mode;
            Processor_Ready <= (state_s == ST_CMD_REQ) || (state_s == ST_RD_REQ);
            i2c_writes      <= !((state_s == ST_RD_REQ) || (state_s == ST_RD_WAIT));
            Busy            <= (state_s != ST_IDLE);
            Sample_Valid    <= (state_s == ST_DONE);
            Sample_Error    <= (state_s == ST_ERROR);
            if ((state_s == ST_DONE) || (state_s == ST_ERROR)) begin
                Retry_Count <= 2'd0;
            end else if ((state_r == ST_RETRY) && (state_s == ST_CMD_REQ)) begin
                Retry_Count <= Retry_Count + 2'd1;
            end else begin
                Retry_Count <= Retry_Count;
            end
            if (state_s == ST_DONE) begin
                Temp_Raw <= temp_sel_s;
                RH_Raw   <= rh_sel_s;
            end else begin
                Temp_Raw <= Temp_Raw;
                RH_Raw   <= RH_Raw;
            end
        end
    end

    // Sticky ready flags and captured words for the read in flight
    always_ff @(posedge clk or negedge Reset_N) begin
        if (!Reset_N) begin
            t_seen_r   <= 1'b0;
            rh_seen_r  <= 1'b0;
            temp_cap_r <= 16'd0;
            rh_cap_r   <= 16'd0;
        end else if (srst) begin
            t_seen_r   <= 1'b0;
            rh_seen_r  <= 1'b0;
            temp_cap_r <= 16'd0;
            rh_cap_r   <= 16'd0;
        end else if (state_s == ST_RD_REQ) begin
            t_seen_r   <= 1'b0;
            rh_seen_r  <= 1'b0;
            temp_cap_r <= temp_cap_r;
            rh_cap_r   <= rh_cap_r;
        end else if (state_r == ST_RD_WAIT) begin
            t_seen_r   <= t_seen_s;
            rh_seen_r  <= rh_seen_s;
            temp_cap_r <= temp_sel_s;
            rh_cap_r   <= rh_sel_s;
        end else begin
            t_seen_r   <= t_seen_r;
            rh_seen_r  <= rh_seen_r;
            temp_cap_r <= temp_cap_r;
            rh_cap_r   <= rh_cap_r;
        end
    end

endmodule

// File: tb/tb_sht40_meas_ctrl.sv
// Randomized bench: behavioural i2c master/sensor model, expected-sample queue and monitor.
module tb_sht40_meas_ctrl;
    import sht40_pkg::*;

    localparam int CONV = 20;
    localparam int PERIOD = 50;
    localparam int TMO = 100;

    typedef struct {
        bit          err;
        logic [15:0] t;
        logic [15:0] rh;
        int          attempts;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        srst = 1'b0;
    logic        start = 1'b0;
    logic        auto_mode = 1'b0;
    logic [2:0]  mst_state = 3'b000;
    logic        t_rdy = 1'b0, rh_rdy = 1'b0, crc_err = 1'b0;
    logic [15:0] t_out = 16'd0, rh_out = 16'd0;
    logic        proc_ready, wr;
    logic [6:0]  paddr;
    logic [7:0]  cmd;
    logic [15:0] temp_raw, rh_raw;
    logic        sample_valid, sample_error, busy;
    logic [1:0]  retry_count;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    logic [31:0] data_q[$];
    int   crc_left = 0;
    bit   stuck_next = 1'b0;
    int   wr_done_cyc = -1;
    logic [15:0] last_t = 16'd0, last_rh = 16'd0;
    bit   gap_chk_en = 1'b0;
    bit   have_sample = 1'b0;

    sht40_meas_ctrl #(
        .CONV_CYCLES   (24'd20),
        .PERIOD_CYCLES (24'd50),
        .TIMEOUT_CYCLES(24'd100)
    ) dut (
        .clk               (clk),
        .Reset_N           (rst_n),
        .srst              (srst),
        .Start             (start),
        .Auto_Mode         (auto_mode),
        .Master_State_Out  (mst_state),
        .Temp_Ready_Out    (t_rdy),
        .RH_Ready_Out      (rh_rdy),
        .CRC_Error_Out     (crc_err),
        .Temperature_Output(t_out),
        .Humidity_Output   (rh_out),
        .Processor_Ready   (proc_ready),
        .i2c_writes        (wr),
        .Peripheral_Address(paddr),
        .Command_Data_Frames(cmd),
        .Temp_Raw          (temp_raw),
        .RH_Raw            (rh_raw),
        .Sample_Valid      (sample_valid),
        .Sample_Error      (sample_error),
        .Retry_Count       (retry_count),
        .Busy              (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Master + sensor model: answers each request after a few busy cycles
    initial begin : master_model
        bit m_busy, m_read, m_stuck;
        int m_left;
        logic [31:0] d;
        m_busy = 1'b0; m_read = 1'b0; m_stuck = 1'b0; m_left = 0;
        forever begin
            @(posedge clk); #1;
            t_rdy = 1'b0; rh_rdy = 1'b0; crc_err = 1'b0;
            if (!rst_n) begin
                m_busy = 1'b0; m_stuck = 1'b0; mst_state = 3'b000;
            end else if (m_busy) begin
                if (m_stuck) begin
                    if (proc_ready) begin
                        m_stuck = 1'b0; m_busy = 1'b0; mst_state = 3'b000;
                    end
                end else if (m_left > 1) begin
                    m_left--;
                end else if (m_left == 1) begin
                    m_left = 0;
                    if (m_read) begin
                        t_rdy = 1'b1; rh_rdy = 1'b1;
                        if (crc_left > 0) begin
                            crc_err = 1'b1; crc_left--;
                            t_out = 16'($urandom); rh_out = 16'($urandom);
                        end else if (data_q.size() > 0) begin
                            d = data_q.pop_front();
                            t_out = d[31:16]; rh_out = d[15:0];
                        end else begin
                            t_out = 16'd0; rh_out = 16'd0;
                        end
                    end
                end else begin
                    m_busy = 1'b0; mst_state = 3'b000;
                    if (!m_read) wr_done_cyc = cyc;
                end
            end else if (proc_ready) begin
                m_busy = 1'b1; mst_state = 3'b010; m_read = !wr;
                m_left = int'($urandom_range(5, 2));
                m_stuck = stuck_next && wr;
                if (m_stuck) stuck_next = 1'b0;
            end
        end
    end

    // Monitor: request spacing checks and scoreboard pop on each sample pulse
    initial begin : monitor
        bit pr_prev, pulse_prev, read_since;
        int writes_n, max_retry, pr_fall_cyc, last_sample_cyc;
        exp_t e;
        pr_prev = 1'b0; pulse_prev = 1'b0; read_since = 1'b0;
        writes_n = 0; max_retry = 0; pr_fall_cyc = 0; last_sample_cyc = 0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                pr_prev = 1'b0; pulse_prev = 1'b0; read_since = 1'b0;
                writes_n = 0; max_retry = 0;
                continue;
            end
            if (int'(retry_count) > max_retry) max_retry = int'(retry_count);
            if (proc_ready && !pr_prev) begin
                if (wr) begin
                    if (writes_n > 0 && !read_since)
                        chk_range("timeout_retry_gap", cyc - pr_fall_cyc, TMO, TMO + 4);
                    else if (writes_n == 0 && gap_chk_en && have_sample)
                        chk_range("auto_period_gap", cyc - last_sample_cyc, PERIOD, PERIOD + 3);
                    writes_n++;
                    read_since = 1'b0;
                end else begin
                    chk_range("conv_gap", cyc - wr_done_cyc, CONV, CONV + 3);
                    read_since = 1'b1;
                end
            end
            if (!proc_ready && pr_prev) pr_fall_cyc = cyc;
            if (pulse_prev) chk("pulse_width", {30'd0, sample_valid, sample_error}, 32'd0);
            if (sample_valid || sample_error) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_sample", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("valid_error_flags", {30'd0, sample_valid, sample_error}, {30'd0, !e.err, e.err});
                    chk("temp_raw", temp_raw, e.t);
                    chk("rh_raw", rh_raw, e.rh);
                    chk("attempts", writes_n, e.attempts);
                    chk("max_retry_count", max_retry, e.attempts - 1);
                    chk("retry_cleared", retry_count, 32'd0);
                end
                writes_n = 0; max_retry = 0; read_since = 1'b0;
                last_sample_cyc = cyc; have_sample = 1'b1;
            end
            pr_prev = proc_ready;
            pulse_prev = sample_valid || sample_error;
        end
    end

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_idle(input int maxc, input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        chk(name, {31'd0, done}, 32'd1);
    endtask

    task automatic run_meas(input logic [15:0] t, input logic [15:0] rh, input int crc_n,
                            input bit stuck, input string name);
        exp_t e;
        crc_left = crc_n;
        stuck_next = stuck;
        if (crc_n >= 4) begin
            e.err = 1'b1; e.t = last_t; e.rh = last_rh; e.attempts = 4;
        end else begin
            data_q.push_back({t, rh});
            e.err = 1'b0; e.t = t; e.rh = rh;
            e.attempts = crc_n + 1 + (stuck ? 1 : 0);
            last_t = t; last_rh = rh;
        end
        exp_q.push_back(e);
        pulse_start();
        wait_idle(1000, name);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_proc_ready"}, proc_ready, 32'd0);
        chk({tag, "_i2c_writes"}, wr, 32'd1);
        chk({tag, "_temp_raw"}, temp_raw, 32'd0);
        chk({tag, "_rh_raw"}, rh_raw, 32'd0);
        chk({tag, "_pulses"}, {sample_valid, sample_error}, 32'd0);
        chk({tag, "_retry"}, retry_count, 32'd0);
        chk({tag, "_busy"}, busy, 32'd0);
        chk({tag, "_addr_cmd"}, {paddr, cmd}, {17'd0, 7'h44, 8'hFD});
    endtask

    initial begin : stimulus
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_values("por");
        rst_n = 1'b1;
        @(negedge clk);

        run_meas(16'hBEEF, 16'h92AB, 0, 1'b0, "nominal_done");

        // Reset asserted in the middle of the conversion wait
        data_q.push_back(32'h1234_5678);
        crc_left = 0;
        wr_done_cyc = -1;
        pulse_start();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (wr_done_cyc >= 0) break;
        end
        repeat (5) @(negedge clk);
        chk("busy_before_reset", busy, 32'd1);
        #2 rst_n = 1'b0;
        #1 chk_reset_values("mid_conv");
        data_q.delete(); exp_q.delete();
        last_t = 16'd0; last_rh = 16'd0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 4; k++)
            run_meas(16'($urandom), 16'($urandom), int'($urandom_range(2, 0)), 1'b0, "random_done");

        run_meas(16'($urandom), 16'($urandom), 1, 1'b0, "crc_retry_done");
        run_meas(16'($urandom), 16'($urandom), 4, 1'b0, "exhaust_done");
        chk("temp_held_after_error", {temp_raw, rh_raw}, {last_t, last_rh});
        run_meas(16'($urandom), 16'($urandom), 0, 1'b1, "timeout_done");

        // Periodic mode: two samples, then drop Auto_Mode during the gap
        data_q.push_back({16'hA5A5, 16'h0F0F});
        data_q.push_back({16'h1357, 16'h2468});
        exp_q.push_back('{1'b0, 16'hA5A5, 16'h0F0F, 1});
        exp_q.push_back('{1'b0, 16'h1357, 16'h2468, 1});
        last_t = 16'h1357; last_rh = 16'h2468;
        have_sample = 1'b0;
        gap_chk_en = 1'b1;
        @(negedge clk); auto_mode = 1'b1;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        chk("auto_samples_seen", exp_q.size(), 32'd0);
        repeat (5) @(negedge clk);
        chk("busy_in_period_wait", busy, 32'd1);
        auto_mode = 1'b0;
        @(posedge clk); #1;
        chk("auto_drop_idle", busy, 32'd0);
        repeat (60) @(negedge clk);
        chk("stays_idle", {busy, proc_ready}, 32'd0);
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
